// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared encodings for the CPU clocking/reset controller: FSM states and rate-select codes.
package cpu_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RATE_SLOW = 2'd0,
        RATE_MED  = 2'd1,
        RATE_FULL = 2'd2,
        RATE_STEP = 2'd3
    } rate_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low key.
// The debounced level follows the synced key only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module key_debounce
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic key_n,
    output logic key_db_n
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_meta_n;
    logic          key_sync_n;
    logic [CW-1:0] stable_cnt;

    // NOTE: non-blocking assignments make every flop sample pre-edge values; blocking ones would collapse the two synchroniser stages into a single wire.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            key_meta_n <= 1'b1;
            key_sync_n <= 1'b1;
            key_db_n   <= 1'b1;
            stable_cnt <= '0;
        end else begin
            key_meta_n <= key_n;
            key_sync_n <= key_meta_n;
            if (key_sync_n == key_db_n) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                key_db_n   <= key_sync_n;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Board-level CPU clocking/reset controller: produces a one-cycle cpu_ce pulse at a selectable rate,
// a stretched enable-aligned cpu_reset, single-step mode and a count of delivered enables.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESET_HOLD      = 16
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        key_reset_n,
    input  logic        key_step_n,
    input  logic [1:0]  rate_sel,
    output logic        cpu_ce,
    output logic        cpu_reset,
    output logic [1:0]  state_o,
    output logic [31:0] ce_count
);

    localparam int            HW        = cnt_width(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD);

    logic                 key_reset_db_n;
    logic                 key_step_db_n;
    logic                 step_prev_n;
    logic                 step_fall;

    logic [1:0]           rate_meta;
    rate_t                rate_sync;
    rate_t                rate_prev;
    logic                 rate_changed;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 div_hit;
    logic                 div_pulse;

    state_t               state;
    state_t               state_next;
    logic [HW-1:0]        hold_cnt;
    logic [HW-1:0]        hold_next;
    logic                 ce_next;
    logic                 reset_next;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_reset_key (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .key_n    (key_reset_n),
        .key_db_n (key_reset_db_n)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_key (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .key_n    (key_step_n),
        .key_db_n (key_step_db_n)
    );

    // Rate switches get a synchroniser only; a change in the synced code restarts the divider.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rate_meta   <= 2'b00;
            rate_sync   <= RATE_SLOW;
            rate_prev   <= RATE_SLOW;
            div_cnt     <= '0;
            step_prev_n <= 1'b1;
        end else begin
            rate_meta   <= rate_sel;
            rate_sync   <= rate_t'(rate_meta);
            rate_prev   <= rate_sync;
            div_cnt     <= rate_changed ? '0 : div_cnt + DIV_WIDTH'(1);
            step_prev_n <= key_step_db_n;
        end
    end

    assign rate_changed = (rate_sync != rate_prev);
    assign step_fall    = step_prev_n & ~key_step_db_n;

    // NOTE: every variable written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        div_hit = 1'b0;
        case (rate_sync)
            RATE_SLOW: div_hit = &div_cnt;
            RATE_MED:  div_hit = &div_cnt[DIV_WIDTH-5:0];
            RATE_FULL: div_hit = 1'b1;
            default:   div_hit = 1'b0;
        endcase
    end

    assign div_pulse = div_hit & ~rate_changed;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        ce_next    = 1'b0;
        reset_next = 1'b0;
        if (!key_reset_db_n) begin
            // A held reset key parks the core in reset without enables; pulsing resumes on release.
            state_next = ST_RST;
            hold_next  = '0;
            reset_next = 1'b1;
        end else begin
            case (state)
                ST_RST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = (rate_sync == RATE_STEP) ? ST_STEP : ST_RUN;
                    end else begin
                        ce_next    = 1'b1;
                        reset_next = 1'b1;
                        hold_next  = hold_cnt + HW'(1);
                    end
                end
                ST_RUN: begin
                    ce_next = div_pulse;
                    if (rate_sync == RATE_STEP) begin
                        state_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    ce_next = step_fall;
                    if (rate_sync != RATE_STEP) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RST;
                    hold_next  = '0;
                    reset_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state     <= ST_RST;
            hold_cnt  <= '0;
            cpu_ce    <= 1'b0;
            cpu_reset <= 1'b1;
            ce_count  <= '0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            cpu_ce    <= ce_next;
            cpu_reset <= reset_next;
            if (cpu_ce && !cpu_reset) begin
                ce_count <= ce_count + 32'd1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: stimulus predicts every cpu_ce pulse (cycle, reset level, state)
// from the rate/debounce/hold rules; a monitor pops predictions whenever cpu_ce is seen.
module tb_cpu_clock_ctrl;

    localparam int DIV_WIDTH = 6;
    localparam int DEB       = 4;
    localparam int HOLD      = 3;

    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    logic        clock_in    = 1'b0;
    logic        reset_in    = 1'b1;
    logic        key_reset_n = 1'b1;
    logic        key_step_n  = 1'b1;
    logic [1:0]  rate_sel    = 2'd0;
    logic        cpu_ce;
    logic        cpu_reset;
    logic [1:0]  state_o;
    logic [31:0] ce_count;

    always #10 clock_in = ~clock_in;

    cpu_clock_ctrl #(
        .DIV_WIDTH       (DIV_WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_HOLD      (HOLD)
    ) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .key_reset_n (key_reset_n),
        .key_step_n  (key_step_n),
        .rate_sel    (rate_sel),
        .cpu_ce      (cpu_ce),
        .cpu_reset   (cpu_reset),
        .state_o     (state_o),
        .ce_count    (ce_count)
    );

    typedef struct {
        int         cyc;
        logic       rst;
        logic [1:0] st;
    } pulse_t;

    pulse_t      exp_q[$];
    pulse_t      mon_p;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    bit          mon_en  = 1'b0;

    // Divider model: pulses at run_c + run_p*m, skipping any that fall inside a reset window.
    int run_c  = 0;
    int run_p  = 0;
    int run_m  = 0;
    int blk_hi = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'd0:    return 1 << DIV_WIDTH;
            2'd1:    return 1 << (DIV_WIDTH - 4);
            2'd2:    return 1;
            default: return 0;
        endcase
    endfunction

    task automatic push_until(input int lim);
        int n;
        if (run_p == 0) return;
        while (run_c + run_p * (run_m + 1) <= lim) begin
            run_m++;
            n = run_c + run_p * run_m;
            if (n > blk_hi) exp_q.push_back('{cyc: n, rst: 1'b0, st: S_RUN});
        end
    endtask

    task automatic advance(input int n);
        push_until(cyc + n);
        repeat (n) begin
            @(negedge clock_in);
            #1;
        end
    endtask

    // Pulses already in flight with the old rate land up to two cycles later; the divider restarts on the third.
    task automatic set_rate(input logic [1:0] r);
        push_until(cyc + 2);
        rate_sel = r;
        run_c    = cyc + 3;
        run_m    = 0;
        run_p    = period_of(r);
    endtask

    task automatic do_reset();
        int k;
        reset_in    = 1'b1;
        rate_sel    = 2'd0;
        key_reset_n = 1'b1;
        key_step_n  = 1'b1;
        run_p       = 0;
        exp_cnt     = 32'd0;
        advance(1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_state", 32'(state_o), 32'(S_RST));
        check("rst_ce_count", ce_count, 32'd0);
        advance(2);
        k        = cyc;
        reset_in = 1'b0;
        for (int i = 1; i <= HOLD; i++) exp_q.push_back('{cyc: k + i, rst: 1'b1, st: S_RST});
        run_c  = k;
        run_m  = 0;
        run_p  = period_of(2'd0);
        blk_hi = k + HOLD + 1;
    endtask

    task automatic step_press(input int hold, input int gap);
        key_step_n = 1'b0;
        exp_q.push_back('{cyc: cyc + DEB + 3, rst: 1'b0, st: S_STEP});
        advance(hold);
        key_step_n = 1'b1;
        advance(gap);
    endtask

    task automatic step_glitch(input int len);
        key_step_n = 1'b0;
        advance(len);
        key_step_n = 1'b1;
        advance(12);
    endtask

    // Bounce low 2, high 1, then low for final_len before release.
    task automatic reset_bounce(input int final_len);
        int j;
        int t;
        int r;
        j = cyc;
        t = j + 3 + 2 + DEB;
        r = j + 3 + final_len + 2 + DEB;
        push_until(t);
        for (int i = 1; i <= HOLD; i++) exp_q.push_back('{cyc: r + i, rst: 1'b1, st: S_RST});
        blk_hi = r + HOLD + 1;
        key_reset_n = 1'b0;
        advance(2);
        key_reset_n = 1'b1;
        advance(1);
        key_reset_n = 1'b0;
        advance(final_len);
        key_reset_n = 1'b1;
        advance(2 + DEB + HOLD + 1 + $urandom_range(20, 8));
    endtask

    always @(negedge clock_in) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: no cpu_ce at cycle %0d (now cycle %0d)", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (cpu_ce === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    mon_p = exp_q.pop_front();
                    check("pulse_cpu_reset", 32'(cpu_reset), 32'(mon_p.rst));
                    check("pulse_state", 32'(state_o), 32'(mon_p.st));
                    check("pulse_ce_count", ce_count, exp_cnt);
                    if (!mon_p.rst) exp_cnt = exp_cnt + 32'd1;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected none", cyc);
                end
            end
        end
    end

    initial begin
        @(negedge clock_in);
        #1;
        mon_en = 1'b1;

        // Reset release, RST pulsing, slow rate
        do_reset();
        advance(5);
        advance(64 * $urandom_range(2, 1) + $urandom_range(10, 0));

        // Rate sweep: medium, full, back to slow
        set_rate(2'd1);
        advance(4 * $urandom_range(6, 3) + $urandom_range(3, 0));
        set_rate(2'd2);
        advance($urandom_range(15, 5));
        set_rate(2'd0);
        advance(64 + $urandom_range(10, 0));

        // Single-step: real presses and sub-threshold glitches
        set_rate(2'd3);
        advance(5);
        check("step_state", 32'(state_o), 32'(S_STEP));
        step_press(20, 15);
        repeat ($urandom_range(4, 2)) begin
            if ($urandom_range(2, 0) == 0) step_glitch($urandom_range(3, 1));
            else step_press($urandom_range(20, 8), $urandom_range(20, 12));
        end

        // Bouncing reset key during RUN
        set_rate(2'd1);
        advance($urandom_range(12, 6));
        reset_bounce($urandom_range(16, 8));
        check("bounce_state", 32'(state_o), 32'(S_RUN));

        // reset_in mid-RUN with five counted pulses
        do_reset();
        advance(5);
        set_rate(2'd2);
        advance(9);
        check("ce_count_before_reset", ce_count, 32'd5);
        do_reset();
        advance(10);

        // Counter wrap from 0xFFFFFFFE across two slow pulses
        force dut.ce_count = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        advance(1);
        release dut.ce_count;
        advance(140);
        check("ce_count_wrap", ce_count, exp_cnt);
        check("ce_count_wrap_zero", ce_count, 32'h0000_0000);

        advance(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
